// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and helpers for the 1xN NoC router
//
// Purpose : package type and FSM state encodings, plus a saturating increment
//           used by the statistics counters.
// Contents: ptype_e     - 2-bit package_type (SINGLE/BURST/CTRL/RESERVED)
//           rtr_state_e - router FSM states (IDLE/FWD/DROP)
//           sat_inc     - increment that holds at max_value instead of wrapping
package noc_pkg;

  typedef enum logic [1:0] {
    SINGLE   = 2'b00,
    BURST    = 2'b01,
    CTRL     = 2'b10,
    RESERVED = 2'b11
  } ptype_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FWD  = 2'b01,
    DROP = 2'b10
  } rtr_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    if (value >= max_value) return value;
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - first-word-fall-through flit FIFO with registered storage
//
// Purpose : buffers input flits; the oldest entry is always visible on rd_data
//           while empty=0. A word written at edge N is visible after edge N
//           (no empty bypass).
// Ports   : clk, reset    - clock, synchronous active-high reset (flushes)
//           push, wr_data - write request/data (ignored when full)
//           pop           - remove head (ignored when empty)
//           rd_data       - current head word
//           full, empty   - occupancy flags
//           count         - number of stored words (0..DEPTH)
module noc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_router_1xn.sv
// rtl/noc_router_1xn.sv - single-input, NUM_OUT-output wormhole NoC router
//
// Purpose : buffers flits in a FWFT FIFO and steers each packet to the output
//           channel named by its head flit. Multi-flit packets hold a lock on
//           that channel until eop. Reserved-type or out-of-range packets are
//           discarded whole and counted.
// Ports   : clk, reset                      - clock, sync active-high reset
//           in_valid/in_ready               - input handshake (ready = FIFO not full)
//           in_dest/in_type/in_payload/in_eop - input flit fields
//           out_valid[NUM_OUT]/out_ready[NUM_OUT] - per-channel handshake
//           out_type/out_payload/out_eop    - shared output data (0 when idle)
//           drop_cnt/fwd_cnt                - saturating packet counters
module noc_router_1xn
  import noc_pkg::*;
#(
  parameter int NUM_OUT   = 4,
  parameter int PAYLOAD_W = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  localparam int DEST_W   = ($clog2(NUM_OUT) > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEST_W-1:0]    in_dest,
  input  logic [1:0]           in_type,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_eop,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [1:0]           out_type,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_eop,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     fwd_cnt
);

  localparam int          FW      = DEST_W + 2 + PAYLOAD_W + 1;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  // FIFO word layout: {dest, type, payload, eop}
  logic [FW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   pop;

  logic [DEST_W-1:0]      h_dest;
  logic [1:0]             h_type;
  logic [PAYLOAD_W-1:0]   h_payload;
  logic                   h_eop;
  logic                   h_bad;

  rtr_state_e             state;
  rtr_state_e             next_state;
  logic [DEST_W-1:0]      lock;
  logic [DEST_W-1:0]      next_lock;
  logic                   sel_valid;
  logic [DEST_W-1:0]      sel;
  logic                   inc_fwd;
  logic                   inc_drop;
  logic                   unused_fifo_count;

  // Held low during reset so nothing is accepted into a FIFO being flushed.
  assign in_ready = !reset && !fifo_full;

  noc_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid && in_ready),
    .wr_data ({in_dest, in_type, in_payload, in_eop}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign h_eop     = head[0];
  assign h_payload = head[PAYLOAD_W:1];
  assign h_type    = head[PAYLOAD_W+2:PAYLOAD_W+1];
  assign h_dest    = head[FW-1:PAYLOAD_W+3];

  // Widen dest before comparing so non-power-of-2 NUM_OUT catches the unused codes.
  assign h_bad = (h_type == RESERVED) || (32'(h_dest) >= 32'(NUM_OUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lock  <= '0;
    end else begin
      state <= next_state;
      lock  <= next_lock;
    end
  end

  always_comb begin
    next_state = state;
    next_lock  = lock;
    pop        = 1'b0;
    sel_valid  = 1'b0;
    sel        = lock;
    inc_fwd    = 1'b0;
    inc_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (h_bad) begin
            pop = 1'b1;
            if (h_eop) inc_drop = 1'b1;
            else       next_state = DROP;
          end else begin
            sel_valid = 1'b1;
            sel       = h_dest;
            if (out_ready[h_dest]) begin
              pop = 1'b1;
              if (h_eop) begin
                inc_fwd = 1'b1;
              end else begin
                next_state = FWD;
                next_lock  = h_dest;
              end
            end
          end
        end
      end
      FWD: begin
        // Body flits follow the lock; their own dest/type fields are ignored.
        if (!fifo_empty) begin
          sel_valid = 1'b1;
          if (out_ready[lock]) begin
            pop = 1'b1;
            if (h_eop) begin
              inc_fwd    = 1'b1;
              next_state = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (h_eop) begin
            inc_drop   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_valid[i] = sel_valid && (32'(sel) == 32'(i));
    end
  end

  assign out_type    = sel_valid ? h_type    : '0;
  assign out_payload = sel_valid ? h_payload : '0;
  assign out_eop     = sel_valid ? h_eop     : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc_fwd)  fwd_cnt  <= CNT_W'(sat_inc(32'(fwd_cnt), CNT_MAX));
      if (inc_drop) drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
    end
  end

endmodule
